// File: rtl/fpu_share_arb.sv
// Round-robin arbiter and sequencer that shares one combinational bfloat16 fpu
// among N_REQ requesters: accept -> issue -> respond, one operation at a time.
module fpu_share_arb #(
   parameter int N_REQ      = 2,
   parameter int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   parameter int DATA_WIDTH = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [N_REQ-1:0]            req_valid_i,
   output logic [N_REQ-1:0]            req_ready_o,
   input  logic [4*N_REQ-1:0]          req_op_i,
   input  logic [DATA_WIDTH*N_REQ-1:0] req_in1_i,
   input  logic [DATA_WIDTH*N_REQ-1:0] req_in2_i,
   output logic [3:0]                  fpu_op_o,
   output logic [DATA_WIDTH-1:0]       fpu_in1_o,
   output logic [DATA_WIDTH-1:0]       fpu_in2_o,
   input  logic [DATA_WIDTH-1:0]       fpu_out_i,
   input  logic                        fpu_overflow_i,
   output logic                        rsp_valid_o,
   input  logic                        rsp_ready_i,
   output logic [ID_W-1:0]             rsp_id_o,
   output logic [DATA_WIDTH-1:0]       rsp_data_o,
   output logic                        rsp_overflow_o,
   output logic                        busy_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t                state, state_nxt;
   logic [ID_W-1:0]       last_grant;
   logic [ID_W-1:0]       grant_id;
   logic                  grant_found;
   logic                  accept;
   logic [3:0]            sel_op;
   logic [DATA_WIDTH-1:0] sel_in1, sel_in2;

   logic [3:0]            op_p0;
   logic [DATA_WIDTH-1:0] in1_p0, in2_p0;
   logic [ID_W-1:0]       id_p0;
   logic [DATA_WIDTH-1:0] data_p1;
   logic                  ovf_p1;

   // Round-robin search starting just after the previous winner.
   always_comb begin
      int              idx;
      logic [ID_W-1:0] idx_w;
      grant_found = 1'b0;
      grant_id    = '0;
      idx         = 0;
      idx_w       = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx   = (int'(last_grant) + 1 + i) % N_REQ;
         idx_w = ID_W'(idx);
         if (!grant_found && req_valid_i[idx_w]) begin
            grant_found = 1'b1;
            grant_id    = idx_w;
         end
      end
   end

   always_comb begin
      sel_op  = '0;
      sel_in1 = '0;
      sel_in2 = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant_id == ID_W'(k)) begin
            sel_op  = req_op_i[k*4 +: 4];
            sel_in1 = req_in1_i[k*DATA_WIDTH +: DATA_WIDTH];
            sel_in2 = req_in2_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign accept = (state == IDLE) && grant_found;

   always_comb begin
      req_ready_o = '0;
      if (accept) begin
         req_ready_o[grant_id] = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_found) state_nxt = ISSUE;
         ISSUE:   state_nxt = RESP;
         RESP:    if (rsp_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p0: operand capture on accept; stage p1: fpu result capture in ISSUE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         last_grant <= ID_W'(N_REQ - 1);
         op_p0      <= '0;
         in1_p0     <= '0;
         in2_p0     <= '0;
         id_p0      <= '0;
         data_p1    <= '0;
         ovf_p1     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            last_grant <= grant_id;
            id_p0      <= grant_id;
            op_p0      <= sel_op;
            in1_p0     <= sel_in1;
            in2_p0     <= sel_in2;
         end
         if (state == ISSUE) begin
            data_p1 <= fpu_out_i;
            ovf_p1  <= fpu_overflow_i;
         end
      end
   end

   assign fpu_op_o       = op_p0;
   assign fpu_in1_o      = in1_p0;
   assign fpu_in2_o      = in2_p0;
   assign rsp_valid_o    = (state == RESP);
   assign rsp_id_o       = id_p0;
   assign rsp_data_o     = data_p1;
   assign rsp_overflow_o = ovf_p1;
   assign busy_o         = (state != IDLE);

endmodule

// File: tb/tb_fpu_share_arb.sv
// Randomized scoreboard bench for fpu_share_arb with N_REQ=4 and a behavioural
// bfloat16 fpu (add/sub/mul via real arithmetic, other opcodes return in1^in2).
module tb_fpu_share_arb;
   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int DW  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic [N-1:0]   req_valid, req_ready;
   logic [4*N-1:0] req_op;
   logic [DW*N-1:0] req_in1, req_in2;
   logic [3:0]     fpu_op;
   logic [DW-1:0]  fpu_in1, fpu_in2, fpu_out;
   logic           fpu_ovf;
   logic           rsp_valid, rsp_ready, rsp_ovf, busy;
   logic [IDW-1:0] rsp_id;
   logic [DW-1:0]  rsp_data;

   logic [N-1:0]   s_valid;
   logic [3:0]     s_op [N];
   logic [15:0]    s_a [N];
   logic [15:0]    s_b [N];

   typedef struct {
      int          id;
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] data;
      logic        ovf;
      int          acc_cyc;
   } exp_t;
   exp_t sbq[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int phase = 0;
   int gnt_cnt [N];
   int seen [N];
   int n_push = 0;
   int n_pop = 0;

   fpu_share_arb #(.N_REQ(N), .ID_W(IDW), .DATA_WIDTH(DW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_op_i(req_op), .req_in1_i(req_in1), .req_in2_i(req_in2),
      .fpu_op_o(fpu_op), .fpu_in1_o(fpu_in1), .fpu_in2_o(fpu_in2),
      .fpu_out_i(fpu_out), .fpu_overflow_i(fpu_ovf),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_overflow_o(rsp_ovf),
      .busy_o(busy)
   );

   function automatic real bf2real(input logic [15:0] h);
      logic [63:0] d;
      if (h[14:7] == 8'h00)      d = {h[15], 63'h0};
      else if (h[14:7] == 8'hFF) d = {h[15], 11'h7FF, h[6:0], 45'h0};
      else                       d = {h[15], 11'(int'(h[14:7]) - 127 + 1023), h[6:0], 45'h0};
      return $bitstoreal(d);
   endfunction

   // Returns {overflow, result}; results truncate toward zero.
   function automatic logic [16:0] fpu_model(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
      real         x, y, r;
      logic [63:0] rb;
      int          e;
      x = bf2real(a);
      y = bf2real(b);
      case (op)
         4'd0:    r = x + y;
         4'd1:    r = x - y;
         4'd2:    r = x * y;
         default: return {1'b0, a ^ b};
      endcase
      rb = $realtobits(r);
      e  = int'(rb[62:52]);
      if (e == 2047) return {1'b0, rb[63], 8'hFF, rb[51:45]};
      e = e - 1023 + 127;
      if (e >= 255) return {1'b1, rb[63], 8'hFF, 7'h0};
      if (e <= 0) return {1'b0, rb[63], 15'h0};
      return {1'b0, rb[63], e[7:0], rb[51:45]};
   endfunction

   always_comb {fpu_ovf, fpu_out} = fpu_model(fpu_op, fpu_in1, fpu_in2);

   always_comb begin
      req_valid = s_valid;
      req_op    = '0;
      req_in1   = '0;
      req_in2   = '0;
      for (int k = 0; k < N; k++) begin
         req_op[k*4 +: 4]    = s_op[k];
         req_in1[k*DW +: DW] = s_a[k];
         req_in2[k*DW +: DW] = s_b[k];
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Reference arbitration model: predicts the grant and pushes the expected response.
   int           m_last = N - 1;
   int           wait_cnt [N];
   int           prev_acc = 0;
   int           last_phase = 0;
   int           win, kk;
   logic         idle;
   logic [N-1:0] exp_ready;
   exp_t         ne;
   logic [16:0]  mres;
   always @(negedge clk) begin
      if (!rst_n) begin
         tests++;
         if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== '0 ||
             rsp_data !== '0 || rsp_ovf !== 1'b0 || fpu_op !== '0 || fpu_in1 !== '0 ||
             fpu_in2 !== '0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b rsp_valid=%b busy=%b id=%0d data=%h ovf=%b op=%h in1=%h in2=%h, required all zero",
                     req_ready, rsp_valid, busy, rsp_id, rsp_data, rsp_ovf, fpu_op, fpu_in1, fpu_in2);
         end
         m_last = N - 1;
         n_push = 0;
         sbq.delete();
         for (int k = 0; k < N; k++) wait_cnt[k] = 0;
      end else begin
         idle = (n_push == n_pop);
         win  = -1;
         if (idle) begin
            for (int i = 1; i <= N; i++) begin
               kk = (m_last + i) % N;
               if (win < 0 && req_valid[kk]) win = kk;
            end
         end
         exp_ready = '0;
         if (win >= 0) exp_ready[win] = 1'b1;
         tests++;
         if (req_ready !== exp_ready) begin
            fails++;
            $display("FAIL grant: req_ready=%b valid=%b, required %b", req_ready, req_valid, exp_ready);
         end
         tests++;
         if ($countones(req_ready) > 1) begin
            fails++;
            $display("FAIL ready_onehot: req_ready=%b, required at most one bit", req_ready);
         end
         tests++;
         if (busy !== !idle) begin
            fails++;
            $display("FAIL busy: busy=%b, required %b", busy, !idle);
         end
         if (win >= 0) begin
            tests++;
            for (int k = 0; k < N; k++) begin
               if (k == win || !req_valid[k]) wait_cnt[k] = 0;
               else wait_cnt[k]++;
            end
            for (int k = 0; k < N; k++) begin
               if (wait_cnt[k] >= N) begin
                  fails++;
                  $display("FAIL fairness: req %0d waited %0d grants, required < %0d", k, wait_cnt[k], N);
               end
            end
            if (phase == 1 && last_phase == 1) begin
               tests++;
               if (cyc - prev_acc != 3) begin
                  fails++;
                  $display("FAIL issue_interval: %0d cycles, required 3", cyc - prev_acc);
               end
            end
            last_phase = phase;
            prev_acc   = cyc;
            mres       = fpu_model(s_op[win], s_a[win], s_b[win]);
            ne.id      = win;
            ne.op      = s_op[win];
            ne.a       = s_a[win];
            ne.b       = s_b[win];
            ne.data    = mres[15:0];
            ne.ovf     = mres[16];
            ne.acc_cyc = cyc;
            sbq.push_back(ne);
            n_push++;
            m_last = win;
            gnt_cnt[win]++;
         end
      end
   end

   // Response monitor: compares each presented response with the scoreboard head.
   logic in_rsp = 1'b0;
   exp_t me;
   always @(negedge clk) begin
      if (!rst_n) begin
         n_pop  <= 0;
         in_rsp = 1'b0;
      end else if (rsp_valid) begin
         if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: id=%0d data=%h, required no response", rsp_id, rsp_data);
         end else begin
            me = sbq[0];
            if (!in_rsp) begin
               tests++;
               if (cyc - me.acc_cyc != 2) begin
                  fails++;
                  $display("FAIL latency: %0d cycles after accept, required 2", cyc - me.acc_cyc);
               end
               in_rsp = 1'b1;
            end
            tests++;
            if (rsp_id !== me.id[IDW-1:0] || rsp_data !== me.data || rsp_ovf !== me.ovf) begin
               fails++;
               $display("FAIL rsp: id=%0d data=%h ovf=%b, required id=%0d data=%h ovf=%b (op=%h a=%h b=%h)",
                        rsp_id, rsp_data, rsp_ovf, me.id, me.data, me.ovf, me.op, me.a, me.b);
            end
            if (me.op == 4'd0 && me.a == 16'h3F80 && me.b == 16'h4000) begin
               tests++;
               if (rsp_data !== 16'h4040 || rsp_ovf !== 1'b0) begin
                  fails++;
                  $display("FAIL add_1_2: data=%h ovf=%b, required 4040 0", rsp_data, rsp_ovf);
               end
            end
            if (me.op == 4'd2 && me.a == 16'h7F00 && me.b == 16'h7F00) begin
               tests++;
               if (rsp_data !== 16'h7F80 || rsp_ovf !== 1'b1) begin
                  fails++;
                  $display("FAIL mul_overflow: data=%h ovf=%b, required 7f80 1", rsp_data, rsp_ovf);
               end
            end
            if (rsp_ready) begin
               void'(sbq.pop_front());
               n_pop <= n_pop + 1;
               in_rsp = 1'b0;
            end
         end
      end
   end

   task automatic set_req(input int k, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      s_op[k]    = op;
      s_a[k]     = a;
      s_b[k]     = b;
      s_valid[k] = 1'b1;
   endtask

   // mode 0: hold pending requests only; 1: keep mask requesters valid; 2: random traffic
   task automatic cycle_drive(input logic [N-1:0] mask, input int mode);
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         if (gnt_cnt[k] != seen[k]) begin
            seen[k]    = gnt_cnt[k];
            s_valid[k] = 1'b0;
         end
         if (!s_valid[k] && mask[k] && (mode == 1 || (mode == 2 && $urandom_range(1, 0) == 1)))
            set_req(k, 4'($urandom_range(15, 0)), 16'($urandom), 16'($urandom));
         else if (s_valid[k] && mode == 2 && $urandom_range(15, 0) == 0)
            s_valid[k] = 1'b0;
      end
      if (mode == 2) rsp_ready = ($urandom_range(2, 0) != 0);
   endtask

   task automatic wait_grant(input int k, input int limit);
      int start;
      start = gnt_cnt[k];
      for (int i = 0; i < limit; i++) begin
         if (gnt_cnt[k] != start) break;
         cycle_drive('0, 0);
      end
      if (gnt_cnt[k] == start) begin
         $display("FAIL grant_timeout: req %0d got no grant in %0d cycles, required one", k, limit);
         $fatal(1, "grant timeout");
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      s_valid   = '0;
      for (int k = 0; k < N; k++) begin
         s_op[k] = '0; s_a[k] = '0; s_b[k] = '0;
         gnt_cnt[k] = 0; seen[k] = 0; wait_cnt[k] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      set_req(0, 4'd0, 16'h3F80, 16'h4000);
      wait_grant(0, 20);
      repeat (4) cycle_drive('0, 0);

      phase = 1;
      repeat (25) cycle_drive(4'b0011, 1);
      phase = 0;
      repeat (12) cycle_drive('0, 0);

      rsp_ready = 1'b0;
      set_req(0, 4'($urandom_range(3, 0)), 16'h4120, 16'h3FC0);
      wait_grant(0, 20);
      repeat (12) cycle_drive(4'b0010, 1);
      rsp_ready = 1'b1;
      repeat (12) cycle_drive('0, 0);

      set_req(2, 4'd2, 16'h7F00, 16'h7F00);
      wait_grant(2, 20);
      repeat (6) cycle_drive('0, 0);

      rsp_ready = 1'b0;
      set_req(3, 4'd1, 16'h3F80, 16'h4000);
      wait_grant(3, 20);
      repeat (2) cycle_drive('0, 0);
      #1 rst_n = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = N - 1; k >= 0; k--) set_req(k, 4'(k), 16'h4000 + 16'(k), 16'h3F80);
      wait_grant(0, 3);
      repeat (20) cycle_drive('0, 0);

      phase = 2;
      repeat (400) cycle_drive(4'b1111, 2);
      phase = 0;
      rsp_ready = 1'b1;
      repeat (20) cycle_drive('0, 0);
      s_valid = '0;
      repeat (6) cycle_drive('0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
